hazard_scoreboard: RTL and testbench

//  Parametrised successor to the single-stage we_stall/we_bypass/curr_rd hazard flags. Tracks every
//  in-flight register write with a per-register latency countdown. Produces the issue stall and
//  per-source bypass selects for the CPU decode/issue stage, for fixed-latency ops (ALU, load, mul)
//  and variable-latency ops (div). Sits between CPU decode and the register file / bypass network.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_sb_entry.sv | 39 +++
 rtl/hazard_scoreboard.sv | 118 +++++++++++
 tb/tb_hazard_scoreboard.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the register-write hazard scoreboard.
package hazard_pkg;

   localparam int unsigned REG_AW  = 5;
   localparam int unsigned LAT_W   = 3;
   localparam int unsigned LAT_MAX = 2 ** LAT_W - 1;

   typedef logic [REG_AW-1:0] reg_idx_t;
   typedef logic [LAT_W-1:0]  lat_t;

   typedef enum logic [2:0] {
      SB_HOLD,
      SB_LOAD,
      SB_WB,
      SB_DEC,
      SB_CLR
   } sb_cmd_e;

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: latency countdown for a single architectural register.
module hazard_sb_entry #(
   parameter int unsigned LAT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       cmd,
   input  logic [LAT_W-1:0] load_val,
   output logic [LAT_W-1:0] cnt,
   output logic [LAT_W-1:0] cnt_next
);
   import hazard_pkg::*;

   logic [LAT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      unique case (sb_cmd_e'(cmd))
         SB_HOLD: cnt_d = cnt_q;
         SB_LOAD: cnt_d = load_val;
         SB_WB:   cnt_d = LAT_W'(1);
         SB_DEC:  cnt_d = cnt_q - LAT_W'(1);
         SB_CLR:  cnt_d = '0;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt      = cnt_q;
   assign cnt_next = cnt_d;

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage hazard scoreboard: per-register write-latency tracking, RAW/WAW stall and
// per-source bypass selection for fixed- and variable-latency units.
module hazard_scoreboard #(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned NUM_SRC  = 2,
   parameter int unsigned LAT_W    = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      issue_valid,
   input  logic                      issue_we,
   input  logic [REG_AW-1:0]         issue_rd,
   input  logic [LAT_W-1:0]          issue_lat,
   input  logic [NUM_SRC*REG_AW-1:0] issue_rs,
   input  logic [NUM_SRC-1:0]        issue_rs_used,
   input  logic                      wb_valid,
   input  logic [REG_AW-1:0]         wb_rd,
   output logic                      stall,
   output logic [NUM_SRC-1:0]        bypass_hit,
   output logic [REG_AW:0]           pending_cnt
);
   import hazard_pkg::*;

   localparam logic [LAT_W-1:0] LatMax = {LAT_W{1'b1}};
   localparam int unsigned      PendW  = REG_AW + 1;

   logic [LAT_W-1:0]  cnt      [NUM_REGS];
   logic [LAT_W-1:0]  cnt_next [NUM_REGS];
   sb_cmd_e           cmd      [NUM_REGS];
   logic [LAT_W-1:0]  load_val;
   logic [REG_AW-1:0] src;
   logic [LAT_W-1:0]  src_cnt;
   logic [LAT_W-1:0]  rd_cnt;
   logic              raw, waw, accept;
   logic [PendW-1:0]  pending_d, pending_q;

   // RAW check and bypass select, using the pre-issue counters
   always_comb begin
      raw        = 1'b0;
      bypass_hit = '0;
      src        = '0;
      src_cnt    = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         src     = issue_rs[i*REG_AW +: REG_AW];
         src_cnt = cnt[src];
         if (issue_rs_used[i] && (src != '0)) begin
            if (src_cnt > LAT_W'(1)) raw = 1'b1;
            if (src_cnt == LAT_W'(1)) bypass_hit[i] = 1'b1;
         end
      end
   end

   // WAW: the new write must not complete before (or with) the outstanding one
   always_comb begin
      rd_cnt = cnt[issue_rd];
      waw    = issue_we && (issue_rd != '0) && (rd_cnt != '0) &&
               ((issue_lat <= rd_cnt) || (rd_cnt == LatMax));
   end

   assign stall    = issue_valid && !flush && (raw || waw);
   assign accept   = issue_valid && !flush && !(raw || waw);
   assign load_val = (issue_lat == '0) ? LAT_W'(1) : issue_lat;

   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         cmd[r] = SB_HOLD;
         if (r != 0) begin
            if (flush) begin
               cmd[r] = SB_CLR;
            end else if (accept && issue_we && (issue_rd == REG_AW'(r))) begin
               cmd[r] = SB_LOAD;
            end else if (wb_valid && (wb_rd == REG_AW'(r)) && (cnt[r] == LatMax)) begin
               cmd[r] = SB_WB;
            end else if ((cnt[r] != '0) && (cnt[r] != LatMax)) begin
               cmd[r] = SB_DEC;
            end
         end
      end
   end

   // x0 is hard-wired idle
   assign cnt[0]      = '0;
   assign cnt_next[0] = '0;

   for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
      hazard_sb_entry #(
         .LAT_W(LAT_W)
      ) u_entry (
         .clk      (clk),
         .rst      (rst),
         .cmd      (cmd[r]),
         .load_val (load_val),
         .cnt      (cnt[r]),
         .cnt_next (cnt_next[r])
      );
   end

   // Count from next-state so pending_cnt tracks the counters cycle for cycle
   always_comb begin
      pending_d = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
         pending_d = pending_d + PendW'(cnt_next[r] != '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign pending_cnt = pending_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed, table-driven bench for hazard_scoreboard plus hand-written reset sequences.
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic       issue_valid;
   logic       issue_we;
   logic [4:0] issue_rd;
   logic [2:0] issue_lat;
   logic [9:0] issue_rs;
   logic [1:0] issue_rs_used;
   logic       wb_valid;
   logic [4:0] wb_rd;
   logic       stall;
   logic [1:0] bypass_hit;
   logic [5:0] pending_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       fl;
      logic       vl;
      logic       we;
      int         rd;
      int         lat;
      int         rs0;
      int         rs1;
      logic [1:0] used;
      logic       wbv;
      int         wbrd;
      logic       es;
      logic [1:0] eb;
      int         ep;
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   hazard_scoreboard #(
      .NUM_REGS (32),
      .REG_AW   (5),
      .NUM_SRC  (2),
      .LAT_W    (3)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .issue_valid   (issue_valid),
      .issue_we      (issue_we),
      .issue_rd      (issue_rd),
      .issue_lat     (issue_lat),
      .issue_rs      (issue_rs),
      .issue_rs_used (issue_rs_used),
      .wb_valid      (wb_valid),
      .wb_rd         (wb_rd),
      .stall         (stall),
      .bypass_hit    (bypass_hit),
      .pending_cnt   (pending_cnt)
   );

   task automatic add(input logic fl, input logic vl, input logic we, input int rd,
                      input int lat, input int rs0, input int rs1, input logic [1:0] used,
                      input logic wbv, input int wbrd, input logic es, input logic [1:0] eb,
                      input int ep);
      vec_t v;
      v.fl = fl; v.vl = vl; v.we = we; v.rd = rd; v.lat = lat; v.rs0 = rs0; v.rs1 = rs1;
      v.used = used; v.wbv = wbv; v.wbrd = wbrd; v.es = es; v.eb = eb; v.ep = ep;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      flush         = v.fl;
      issue_valid   = v.vl;
      issue_we      = v.we;
      issue_rd      = 5'(v.rd);
      issue_lat     = 3'(v.lat);
      issue_rs      = {5'(v.rs1), 5'(v.rs0)};
      issue_rs_used = v.used;
      wb_valid      = v.wbv;
      wb_rd         = 5'(v.wbrd);
   endtask

   task automatic idle_inputs();
      flush = 1'b0; issue_valid = 1'b0; issue_we = 1'b0; issue_rd = '0; issue_lat = '0;
      issue_rs = '0; issue_rs_used = '0; wb_valid = 1'b0; wb_rd = '0;
   endtask

   initial begin
      //  fl vl we rd lat rs0 rs1 used  wbv wbrd  stall byp   pend
      add(0, 1, 0, 0, 0, 5, 0, 2'b01, 0, 0,   0, 2'b00, 0);  // reset state
      add(0, 1, 1, 5, 2, 0, 0, 2'b00, 0, 0,   0, 2'b00, 0);  // rd5 lat2
      add(0, 1, 0, 0, 0, 5, 0, 2'b01, 0, 0,   1, 2'b00, 1);
      add(0, 1, 0, 0, 0, 5, 0, 2'b01, 0, 0,   0, 2'b01, 1);
      add(0, 1, 0, 0, 0, 5, 0, 2'b01, 0, 0,   0, 2'b00, 0);
      add(0, 1, 1, 5, 3, 0, 0, 2'b00, 0, 0,   0, 2'b00, 0);  // rd5 lat3
      add(0, 1, 0, 0, 0, 5, 0, 2'b01, 0, 0,   1, 2'b00, 1);
      add(0, 1, 0, 0, 0, 0, 5, 2'b10, 0, 0,   1, 2'b00, 1);
      add(0, 1, 0, 0, 0, 0, 5, 2'b10, 0, 0,   0, 2'b10, 1);
      add(0, 1, 1, 0, 4, 0, 0, 2'b01, 0, 0,   0, 2'b00, 0);  // x0 write ignored
      add(0, 1, 0, 0, 0, 0, 0, 2'b01, 0, 0,   0, 2'b00, 0);
      add(0, 1, 1, 3, 7, 0, 0, 2'b00, 0, 0,   0, 2'b00, 0);  // rd3 variable
      add(0, 1, 0, 0, 0, 3, 0, 2'b00, 0, 0,   0, 2'b00, 1);  // unused source
      add(0, 1, 0, 0, 0, 3, 0, 2'b01, 0, 0,   1, 2'b00, 1);
      add(0, 1, 1, 3, 1, 0, 0, 2'b00, 0, 0,   1, 2'b00, 1);  // WAW on variable
      add(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 4,   0, 2'b00, 1);  // wb to idle reg
      add(0, 1, 0, 0, 0, 3, 0, 2'b01, 1, 3,   1, 2'b00, 1);  // wb rd3
      add(0, 1, 0, 0, 0, 3, 0, 2'b01, 0, 0,   0, 2'b01, 1);
      add(0, 1, 1, 3, 1, 3, 0, 2'b01, 0, 0,   0, 2'b00, 0);  // WAW drained
      add(0, 0, 0, 0, 0, 3, 0, 2'b01, 0, 0,   0, 2'b01, 1);
      add(0, 1, 1, 6, 2, 0, 0, 2'b00, 0, 0,   0, 2'b00, 0);
      add(0, 1, 1, 6, 3, 0, 0, 2'b00, 0, 0,   0, 2'b00, 1);  // lat > cnt: accept
      add(0, 1, 1, 6, 3, 0, 0, 2'b00, 0, 0,   1, 2'b00, 1);  // lat == cnt: stall
      add(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0,   0, 2'b00, 1);
      add(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0,   0, 2'b00, 1);
      add(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0,   0, 2'b00, 0);
      add(0, 1, 1, 9, 2, 9, 0, 2'b01, 0, 0,   0, 2'b00, 0);  // rs == rd
      add(0, 1, 1, 9, 4, 9, 0, 2'b01, 0, 0,   1, 2'b00, 1);
      add(0, 1, 1, 9, 4, 9, 0, 2'b01, 0, 0,   0, 2'b01, 1);  // reload on cnt==1
      add(0, 0, 0, 0, 0, 9, 0, 2'b01, 0, 0,   0, 2'b00, 1);
      add(0, 1, 1, 10, 0, 0, 0, 2'b00, 0, 0,  0, 2'b00, 1);  // lat0 -> 1
      add(0, 0, 0, 0, 0, 10, 9, 2'b11, 0, 0,  0, 2'b01, 2);
      add(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0,   0, 2'b00, 1);
      add(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0,   0, 2'b00, 0);
      add(0, 1, 1, 1, 6, 0, 0, 2'b00, 0, 0,   0, 2'b00, 0);  // fill three
      add(0, 1, 1, 2, 6, 0, 0, 2'b00, 0, 0,   0, 2'b00, 1);
      add(0, 1, 1, 31, 7, 0, 0, 2'b00, 0, 0,  0, 2'b00, 2);
      add(1, 1, 1, 4, 5, 1, 0, 2'b01, 0, 0,   0, 2'b00, 3);  // flush + issue
      add(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0,   0, 2'b00, 0);
      add(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 31,  0, 2'b00, 0);  // stale wb
      add(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0,   0, 2'b00, 0);

      // Reset held: outputs quiet even with a live issue
      idle_inputs();
      rst = 1'b1;
      issue_valid = 1'b1; issue_rs = 10'd5; issue_rs_used = 2'b01;
      #3;
      check("rst_stall", -1, 32'(stall), 32'd0);
      check("rst_bypass", -1, 32'(bypass_hit), 32'd0);
      check("rst_pending", -1, 32'(pending_cnt), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      idle_inputs();
      rst = 1'b0;

      for (int k = 0; k < tbl.size(); k++) begin
         @(negedge clk);
         drive(tbl[k]);
         #1;
         check("stall", k, 32'(stall), 32'(tbl[k].es));
         check("bypass_hit", k, 32'(bypass_hit), 32'(tbl[k].eb));
         check("pending_cnt", k, 32'(pending_cnt), 32'(tbl[k].ep));
      end

      // Asynchronous reset mid-countdown
      @(negedge clk);
      idle_inputs();
      issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd8; issue_lat = 3'd6;
      @(negedge clk);
      idle_inputs();
      issue_valid = 1'b1; issue_rs = 10'd8; issue_rs_used = 2'b01;
      #1;
      check("pre_rst_stall", -2, 32'(stall), 32'd1);
      check("pre_rst_pending", -2, 32'(pending_cnt), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_pending", -2, 32'(pending_cnt), 32'd0);
      check("async_rst_stall", -2, 32'(stall), 32'd0);
      check("async_rst_bypass", -2, 32'(bypass_hit), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
      wb_valid = 1'b1; wb_rd = 5'd8;
      @(negedge clk);
      idle_inputs();
      issue_valid = 1'b1; issue_rs = 10'd8; issue_rs_used = 2'b01;
      #1;
      check("post_rst_wb_stall", -3, 32'(stall), 32'd0);
      check("post_rst_wb_bypass", -3, 32'(bypass_hit), 32'd0);
      check("post_rst_wb_pending", -3, 32'(pending_cnt), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
